prim_ram_1p_parity_adapter: RTL

- Valid/ready front end that sits directly upstream of a single-port SRAM model (e.g. the bad-bit RAM) and drives its req/write/addr/wdata/wmask pins.
- Adds even parity per data byte on writes and checks it on reads.
- Buffers read responses in a 2-entry FIFO so response backpressure never drops data.
- Lets benches observe the effect of injected bit flips as rsp_err_o.

---
 rtl/prim_ram_1p_parity_adapter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/prim_ram_1p_parity_adapter.sv
// Valid/ready front end for a single-port SRAM.
// - Writes: appends even parity per data byte and builds a bit-level write mask.
// - Reads: checks parity one cycle after the RAM request and queues {err, data}
//   in a 2-entry response FIFO; requests are gated by a credit rule, so
//   response backpressure never loses data.
// Optional feature: define PRIM_RAM_1P_PARITY_ADAPTER_ERR_CNT_EN to get a
// saturating 16-bit parity error counter on err_cnt_o (tied to 0 otherwise).
module prim_ram_1p_parity_adapter #(
  parameter int DataWidth = 32,
  parameter int Depth     = 128,
  localparam int Aw       = $clog2(Depth),
  localparam int NumBytes = DataWidth / 8,
  localparam int MemWidth = DataWidth + NumBytes
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // request channel
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_write_i,
  input  logic [Aw-1:0]        req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [NumBytes-1:0]  req_be_i,
  // response channel
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 rsp_err_o,
  // RAM side
  output logic                 mem_req_o,
  output logic                 mem_write_o,
  output logic [Aw-1:0]        mem_addr_o,
  output logic [MemWidth-1:0]  mem_wdata_o,
  output logic [MemWidth-1:0]  mem_wmask_o,
  input  logic [MemWidth-1:0]  mem_rdata_i,
  // status
  output logic [15:0]          err_cnt_o
);

  // One FIFO entry: parity verdict plus the raw data bits.
  typedef struct packed {
    logic                 err;
    logic [DataWidth-1:0] data;
  } rsp_t;

  // Even parity of every data byte, one bit per byte.
  function automatic logic [NumBytes-1:0] byte_parity(input logic [DataWidth-1:0] d);
    logic [NumBytes-1:0] p;
    p = '0;
    for (int i = 0; i < NumBytes; i++) begin
      p[i] = ^d[8*i +: 8];
    end
    return p;
  endfunction

  logic       pending_q;
  logic [1:0] fifo_cnt_q;
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  rsp_t       fifo_q [2];
  rsp_t       head;
  rsp_t       push_entry;
  logic       push;
  logic       pop;
  logic [2:0] occupancy;

  // ---------------------------------------------------------------------------
  // Credit rule: FIFO entries plus the read in flight, minus the entry leaving
  // this cycle, must stay below two. The rsp_ready_i -> req_ready_o path is
  // what lets a read be accepted every cycle while responses are consumed.
  // ---------------------------------------------------------------------------
  assign rsp_valid_o = (fifo_cnt_q != 2'd0);
  assign pop         = rsp_valid_o & rsp_ready_i;
  assign occupancy   = {1'b0, fifo_cnt_q} + {2'b00, pending_q} - {2'b00, pop};
  assign req_ready_o = (occupancy < 3'd2);

  // ---------------------------------------------------------------------------
  // RAM request: pass-through of the accepted request with parity appended.
  // ---------------------------------------------------------------------------
  assign mem_req_o   = req_valid_i & req_ready_o;
  assign mem_write_o = req_write_i;
  assign mem_addr_o  = req_addr_i;
  assign mem_wdata_o = {byte_parity(req_wdata_i), req_wdata_i};

  // Expand byte enables into a bit mask covering data bytes and their parity bits.
  always_comb begin
    // NOTE: a default before the loop keeps every bit assigned on every pass,
    // so no latch can be inferred.
    mem_wmask_o = '0;
    for (int i = 0; i < NumBytes; i++) begin
      mem_wmask_o[8*i +: 8]      = {8{req_be_i[i]}};
      mem_wmask_o[DataWidth + i] = req_be_i[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Read return path: RAM data is valid the cycle after the read handshake.
  // ---------------------------------------------------------------------------
  assign push            = pending_q;
  assign push_entry.data = mem_rdata_i[DataWidth-1:0];
  assign push_entry.err  = |(mem_rdata_i[MemWidth-1:DataWidth] ^ byte_parity(mem_rdata_i[DataWidth-1:0]));

  // Track the single read whose RAM data arrives next cycle.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignment for all clocked state, so every flop
    // samples the pre-edge values regardless of block ordering.
    if (rst_i) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= mem_req_o & ~req_write_i;
    end
  end

  // FIFO occupancy and pointers; reset flushes any queued responses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fifo_cnt_q <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // FIFO storage: written on push only.
  always_ff @(posedge clk_i) begin
    // NOTE: the entry storage is deliberately not reset; fifo_cnt_q decides
    // what is valid and the outputs below are masked while the FIFO is empty.
    if (push) begin
      fifo_q[wr_ptr_q] <= push_entry;
    end
  end

  // Head of FIFO drives the response; zero while empty so idle outputs are clean.
  assign head        = fifo_q[rd_ptr_q];
  assign rsp_rdata_o = rsp_valid_o ? head.data : '0;
  assign rsp_err_o   = rsp_valid_o & head.err;

  // The credit rule makes a push into a full FIFO unreachable.
  push_while_full_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && (fifo_cnt_q == 2'd2)));

  // ---------------------------------------------------------------------------
  // Parity error counter.
  // ---------------------------------------------------------------------------
`ifdef PRIM_RAM_1P_PARITY_ADAPTER_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  // Count every erroneous entry entering the FIFO, saturating at all ones.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_q <= 16'h0;
    end else if (push && push_entry.err && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = 16'h0;
`endif

endmodule
